instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of `core`. Takes the PC driven by `core` (`o_pc`), fetches the 32-bit instruction from a variable-latency instruction memory over a req/ack interface, and presents it on `o_instr` (→ `core.i_instr`). A one-entry holding register supplies the instruction while the PC is unchanged. `o_stall` freezes the PC until the instruction for the current PC is available.

---
 rtl/core_defs_pkg.sv | 14 +
 rtl/fetch_timeout_ctr.sv | 29 ++
 rtl/instr_fetch.sv | 137 +++++++++++++
 tb/tb_instr_fetch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_defs_pkg.sv
// Shared definitions for the fetch path: FSM state encoding, instruction
// width and the default no-op instruction substituted on fetch errors.
package core_defs_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

endpackage : core_defs_pkg

// File: rtl/fetch_timeout_ctr.sv
// Ack-wait cycle counter for instr_fetch; tc is high once TIMEOUT_P-1 wait
// cycles have elapsed since the last clear.
module fetch_timeout_ctr #(
  parameter int TIMEOUT_P = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT_P > 2) ? $clog2(TIMEOUT_P) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_P - 1);

  logic [CNT_W-1:0] count_q;

  // Saturate at the terminal count so a late ack cannot wrap the counter.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable && !tc) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc = (count_q == LAST);

endmodule : fetch_timeout_ctr

// File: rtl/instr_fetch.sv
// Instruction fetch stage with a one-entry holding register and a req/ack
// memory port. Optional ack timeout enabled by INSTR_FETCH_TIMEOUT_EN.
module instr_fetch
  import core_defs_pkg::*;
#(
  parameter int                      DATA_WIDTH_P = INSTR_W,
  parameter int                      TIMEOUT_P    = 64,
  parameter logic [DATA_WIDTH_P-1:0] NOP_P        = DATA_WIDTH_P'(NOP_INSTR)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH_P-1:0] i_pc,
  output logic [DATA_WIDTH_P-1:0] o_instr,
  output logic                    o_stall,
  output logic                    o_imem_req,
  output logic [DATA_WIDTH_P-1:0] o_imem_addr,
  input  logic                    i_imem_ack,
  input  logic [DATA_WIDTH_P-1:0] i_imem_rdata,
  output logic                    o_misaligned,
  output logic                    o_fetch_err
);

  fetch_state_e            state_q, state_d;
  logic [DATA_WIDTH_P-1:0] req_addr_q;
  logic                    cur_valid_q;
  logic [DATA_WIDTH_P-1:0] cur_addr_q;
  logic [DATA_WIDTH_P-1:0] cur_data_q;

  logic                    misaligned;
  logic                    hit;
  logic                    timeout;
  logic                    latch_req;
  logic                    fill;
  logic [DATA_WIDTH_P-1:0] fill_data;

  assign misaligned = |i_pc[1:0];
  assign hit        = cur_valid_q && (i_pc == cur_addr_q);

`ifdef INSTR_FETCH_TIMEOUT_EN
  logic tc;
  logic err_q;

  // Counter is held clear in IDLE, so every REQ starts counting from zero.
  fetch_timeout_ctr #(
    .TIMEOUT_P (TIMEOUT_P)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == IDLE),
    .enable ((state_q == REQ) && !i_imem_ack),
    .tc     (tc)
  );

  assign timeout = (state_q == REQ) && !i_imem_ack && tc;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign o_fetch_err = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_P;
  assign timeout            = 1'b0;
  assign o_fetch_err        = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    o_instr   = cur_data_q;
    o_stall   = 1'b1;
    latch_req = 1'b0;
    fill      = 1'b0;
    fill_data = i_imem_rdata;

    unique case (state_q)
      IDLE: begin
        if (misaligned) begin
          o_instr = NOP_P;
          o_stall = 1'b0;
        end else if (hit) begin
          o_stall = 1'b0;
        end else begin
          latch_req = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        // An ack in the terminal cycle takes priority over the timeout.
        if (i_imem_ack) begin
          fill    = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          fill      = 1'b1;
          fill_data = NOP_P;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      cur_valid_q <= 1'b0;
      cur_addr_q  <= '0;
      cur_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        req_addr_q <= i_pc;
      end
      // The fill is tagged with the requested address, not the current PC.
      if (fill) begin
        cur_valid_q <= 1'b1;
        cur_addr_q  <= req_addr_q;
        cur_data_q  <= fill_data;
      end
    end
  end

  assign o_imem_req   = (state_q == REQ);
  assign o_imem_addr  = req_addr_q;
  assign o_misaligned = misaligned;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: the driver queues expected request
// addresses and instructions, a negedge monitor pops and compares them.
module tb_instr_fetch;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] i_pc;
  logic [W-1:0] o_instr;
  logic         o_stall;
  logic         o_imem_req;
  logic [W-1:0] o_imem_addr;
  logic         i_imem_ack;
  logic [W-1:0] i_imem_rdata;
  logic         o_misaligned;
  logic         o_fetch_err;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_addr[$];
  logic [W-1:0] exp_instr[$];

  always #5 clk = ~clk;

  instr_fetch #(
    .DATA_WIDTH_P (W),
    .TIMEOUT_P    (8),
    .NOP_P        (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_pc         (i_pc),
    .o_instr      (o_instr),
    .o_stall      (o_stall),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
    .o_misaligned (o_misaligned),
    .o_fetch_err  (o_fetch_err)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [W-1:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%h expected=<none queued>", name, act);
  endtask

  // Monitor: pop an expected address on each new request, an expected
  // instruction on each non-stalled cycle.
  logic         prev_req = 1'b0;
  logic [W-1:0] cur_req_addr = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (o_imem_req && !prev_req) begin
        if (exp_addr.size() == 0) fail_now("unexpected_req", o_imem_addr);
        else check("req_addr", o_imem_addr, exp_addr.pop_front());
        cur_req_addr <= o_imem_addr;
      end else if (o_imem_req) begin
        check("req_addr_stable", o_imem_addr, cur_req_addr);
      end
      if (o_stall === 1'b0) begin
        if (exp_instr.size() == 0) fail_now("unexpected_instr", o_instr);
        else check("instr", o_instr, exp_instr.pop_front());
      end
    end
    prev_req <= reset ? 1'b0 : o_imem_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Miss at pc, ack after wait_cyc extra REQ cycles; ends at the hit cycle.
  task automatic fetch(input logic [W-1:0] pc, input logic [W-1:0] data, input int wait_cyc);
    int stalls;
    stalls = 0;
    i_pc = pc;
    exp_addr.push_back(pc);
    #1;
    if (o_stall) stalls++;
    step();
    for (int i = 0; i < wait_cyc; i++) begin
      #1;
      if (o_stall) stalls++;
      step();
    end
    i_imem_ack   = 1'b1;
    i_imem_rdata = data;
    #1;
    if (o_stall) stalls++;
    step();
    i_imem_ack   = 1'b0;
    i_imem_rdata = 32'hdead_beef;
    check("fetch_stall_cycles", W'(stalls), W'(2 + wait_cyc));
  endtask

  task automatic hold(input int n, input logic [W-1:0] data);
    for (int i = 0; i < n; i++) begin
      exp_instr.push_back(data);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    i_pc         = '0;
    i_imem_ack   = 1'b0;
    i_imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_instr", o_instr, 32'h0);
    check("rst_stall", W'(o_stall), 32'h1);
    check("rst_req", W'(o_imem_req), 32'h0);
    check("rst_addr", o_imem_addr, 32'h0);
    check("rst_err", W'(o_fetch_err), 32'h0);
    check("rst_misaligned", W'(o_misaligned), 32'h0);

    // First fetch, then the same PC held: no new request, never stalls.
    fetch(32'h0, 32'h2008_0005, 0);
    hold(6, 32'h2008_0005);

    // Ack while IDLE must not disturb the held entry.
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'hbad0_0bad;
    exp_instr.push_back(32'h2008_0005);
    step();
    i_imem_ack = 1'b0;
    hold(2, 32'h2008_0005);

    // PC moves mid-REQ: 0x4 completes, then 0x8 is re-fetched.
    i_pc = 32'h4;
    exp_addr.push_back(32'h4);
    step();
    i_pc = 32'h8;
    exp_addr.push_back(32'h8);
    step();
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h0000_a004;
    step();
    i_imem_ack = 1'b0;
    #1;
    check("stale_fill_miss", W'(o_stall), 32'h1);
    step();
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h0000_a008;
    step();
    i_imem_ack = 1'b0;
    hold(2, 32'h0000_a008);

    // Ack and PC change together: the entry is tagged with 0x10.
    i_pc = 32'h10;
    exp_addr.push_back(32'h10);
    step();
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h0000_d010;
    i_pc         = 32'h14;
    step();
    i_imem_ack = 1'b0;
    i_pc       = 32'h10;
    hold(2, 32'h0000_d010);

    // Misaligned PC: NOP, no stall, no request.
    i_pc = 32'h6;
    #1;
    check("mis_flag", W'(o_misaligned), 32'h1);
    check("mis_stall", W'(o_stall), 32'h0);
    check("mis_instr", o_instr, 32'h0);
    check("mis_req", W'(o_imem_req), 32'h0);
    hold(3, 32'h0);
    i_pc = 32'h10;
    #1;
    check("aligned_flag", W'(o_misaligned), 32'h0);
    hold(1, 32'h0000_d010);

`ifndef INSTR_FETCH_TIMEOUT_EN
    // Without the timeout feature a long ack wait simply stalls longer.
    fetch(32'h30, 32'h0000_d030, 10);
    check("no_timeout_err", W'(o_fetch_err), 32'h0);
    hold(1, 32'h0000_d030);
`endif

    // Reset in the third REQ cycle abandons the request and the entry.
    i_pc = 32'h20;
    exp_addr.push_back(32'h20);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    i_pc  = 32'h0;
    #1;
    check("rst_mid_req", W'(o_imem_req), 32'h0);
    check("rst_mid_err", W'(o_fetch_err), 32'h0);
    check("rst_mid_entry_cleared", W'(o_stall), 32'h1);
    fetch(32'h0, 32'h1111_2222, 1);
    hold(1, 32'h1111_2222);

`ifdef INSTR_FETCH_TIMEOUT_EN
    begin
      int req_cycles;
      req_cycles = 0;
      i_pc = 32'h40;
      exp_addr.push_back(32'h40);
      step();
      while (o_imem_req && req_cycles < 20) begin
        req_cycles++;
        step();
      end
      check("timeout_req_cycles", W'(req_cycles), 32'h8);
      check("timeout_err", W'(o_fetch_err), 32'h1);
      hold(1, 32'h0);
      fetch(32'h44, 32'h0000_d044, 0);
      check("timeout_err_sticky", W'(o_fetch_err), 32'h1);
      hold(1, 32'h0000_d044);
    end
`endif

    check("instr_queue_drained", W'(exp_instr.size()), 32'h0);
    check("addr_queue_drained", W'(exp_addr.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_fetch
